// File: rtl/uart_bram_loader.sv
// Command-driven UART <-> BRAM sequencer: parses an opcode/length header, then either
// packs received bytes into 32-bit words written to port B, or streams port-A words out via UART.
module uart_bram_loader #(
  parameter int DEPTH          = 25000,
  parameter int ADDR_WIDTH     = $clog2(DEPTH),
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rx_valid_in,
  input  logic [7:0]            rx_byte_in,
  input  logic                  tx_busy_in,
  output logic                  tx_trigger_out,
  output logic [7:0]            tx_byte_out,
  output logic [ADDR_WIDTH-1:0] bram_waddr_out,
  output logic [31:0]           bram_wdata_out,
  output logic                  bram_we_out,
  output logic [ADDR_WIDTH-1:0] bram_raddr_out,
  input  logic [31:0]           bram_rdata_in,
  output logic                  busy_out,
  output logic                  done_out,
  output logic                  error_out
);
  typedef enum logic [3:0] {
    IDLE, HDR_LO, HDR_HI, LOAD, DUMP_RD, DUMP_WAIT, DUMP_SEND, TX_WAIT_HI, TX_WAIT_LO
  } state_t;

  localparam int              TW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]   T_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [16:0]     DEPTH_W = 17'(DEPTH);
  localparam logic [7:0]      OP_LOAD = 8'h4C;
  localparam logic [7:0]      OP_DUMP = 8'h44;

  state_t                r_state, w_state_nx;
  logic                  r_is_dump, w_is_dump_nx;
  logic [15:0]           r_len, w_len_nx;
  logic [15:0]           r_idx, w_idx_nx;
  logic [1:0]            r_bsel, w_bsel_nx;
  logic [23:0]           r_pack, w_pack_nx;
  logic [31:0]           r_word, w_word_nx;
  logic                  r_fin, w_fin_nx;
  logic [TW-1:0]         r_tcnt, w_tcnt_nx;
  logic [1:0]            r_wcnt, w_wcnt_nx;
  logic                  r_trig, w_trig_nx;
  logic [7:0]            r_tx_byte, w_tx_byte_nx;
  logic [ADDR_WIDTH-1:0] r_waddr, w_waddr_nx;
  logic [31:0]           r_wdata, w_wdata_nx;
  logic                  r_we, w_we_nx;
  logic [ADDR_WIDTH-1:0] r_raddr, w_raddr_nx;
  logic                  r_busy, w_busy_nx;
  logic                  r_done, w_done_nx;
  logic                  r_err, w_err_nx;
  logic [15:0]           w_n;
  logic                  w_last;

  always_comb begin
    w_state_nx   = r_state;
    w_is_dump_nx = r_is_dump;
    w_len_nx     = r_len;
    w_idx_nx     = r_idx;
    w_bsel_nx    = r_bsel;
    w_pack_nx    = r_pack;
    w_word_nx    = r_word;
    w_fin_nx     = r_fin;
    w_tcnt_nx    = r_tcnt;
    w_wcnt_nx    = r_wcnt;
    w_trig_nx    = 1'b0;
    w_tx_byte_nx = r_tx_byte;
    w_waddr_nx   = r_waddr;
    w_wdata_nx   = r_wdata;
    w_we_nx      = 1'b0;
    w_raddr_nx   = r_raddr;
    w_done_nx    = 1'b0;
    w_err_nx     = r_err;
    w_n          = {rx_byte_in, r_len[7:0]};
    w_last       = (r_idx == r_len - 16'd1);

    case (r_state)
      IDLE: if (rx_valid_in) begin
        w_err_nx  = 1'b0;
        w_tcnt_nx = '0;
        if (rx_byte_in == OP_LOAD || rx_byte_in == OP_DUMP) begin
          w_is_dump_nx = (rx_byte_in == OP_DUMP);
          w_state_nx   = HDR_LO;
        end else begin
          w_err_nx = 1'b1;
        end
      end
      HDR_LO: if (rx_valid_in) begin
        w_len_nx[7:0] = rx_byte_in;
        w_state_nx    = HDR_HI;
      end
      HDR_HI: if (rx_valid_in) begin
        w_len_nx  = w_n;
        w_idx_nx  = '0;
        w_bsel_nx = '0;
        w_fin_nx  = 1'b0;
        if (w_n == 16'd0) begin
          w_done_nx  = 1'b1;
          w_state_nx = IDLE;
        end else if ({1'b0, w_n} > DEPTH_W) begin
          w_err_nx   = 1'b1;
          w_state_nx = IDLE;
        end else if (r_is_dump) begin
          w_raddr_nx = '0;
          w_state_nx = DUMP_RD;
        end else begin
          w_state_nx = LOAD;
        end
      end
      // r_fin gives the final write its own cycle so done trails the last we by one
      LOAD: if (r_fin) begin
        w_done_nx  = 1'b1;
        w_state_nx = IDLE;
      end else if (rx_valid_in) begin
        if (r_bsel == 2'd3) begin
          w_we_nx    = 1'b1;
          w_waddr_nx = r_idx[ADDR_WIDTH-1:0];
          w_wdata_nx = {rx_byte_in, r_pack};
          w_bsel_nx  = '0;
          if (w_last) w_fin_nx = 1'b1;
          else        w_idx_nx = r_idx + 16'd1;
        end else begin
          w_pack_nx[8*r_bsel +: 8] = rx_byte_in;
          w_bsel_nx = r_bsel + 2'd1;
        end
      end
      DUMP_RD: begin
        w_wcnt_nx  = '0;
        w_state_nx = DUMP_WAIT;
      end
      DUMP_WAIT: if (r_wcnt == 2'd1) begin
        w_word_nx  = bram_rdata_in;
        w_bsel_nx  = '0;
        w_state_nx = DUMP_SEND;
      end else begin
        w_wcnt_nx = r_wcnt + 2'd1;
      end
      DUMP_SEND: if (!tx_busy_in) begin
        w_trig_nx    = 1'b1;
        w_tx_byte_nx = r_word[8*r_bsel +: 8];
        w_wcnt_nx    = '0;
        w_state_nx   = TX_WAIT_HI;
      end
      TX_WAIT_HI: if (tx_busy_in) begin
        w_state_nx = TX_WAIT_LO;
      end else if (r_wcnt == 2'd3) begin
        w_err_nx   = 1'b1;
        w_state_nx = IDLE;
      end else begin
        w_wcnt_nx = r_wcnt + 2'd1;
      end
      TX_WAIT_LO: if (!tx_busy_in) begin
        if (r_bsel == 2'd3) begin
          w_bsel_nx = '0;
          if (w_last) begin
            w_done_nx  = 1'b1;
            w_state_nx = IDLE;
          end else begin
            w_idx_nx   = r_idx + 16'd1;
            w_raddr_nx = w_idx_nx[ADDR_WIDTH-1:0];
            w_state_nx = DUMP_RD;
          end
        end else begin
          w_bsel_nx  = r_bsel + 2'd1;
          w_state_nx = DUMP_SEND;
        end
      end
      default: w_state_nx = IDLE;
    endcase

    // Inter-byte timeout; a partial word in r_pack is simply abandoned
    if ((r_state inside {HDR_LO, HDR_HI, LOAD}) && !r_fin) begin
      if (rx_valid_in) begin
        w_tcnt_nx = '0;
      end else if (r_tcnt == T_LAST) begin
        w_err_nx   = 1'b1;
        w_state_nx = IDLE;
      end else begin
        w_tcnt_nx = r_tcnt + 1'b1;
      end
    end

    w_busy_nx = (w_state_nx != IDLE);
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state   <= IDLE;
      r_is_dump <= 1'b0;
      r_len     <= '0;
      r_idx     <= '0;
      r_bsel    <= '0;
      r_pack    <= '0;
      r_word    <= '0;
      r_fin     <= 1'b0;
      r_tcnt    <= '0;
      r_wcnt    <= '0;
      r_trig    <= 1'b0;
      r_tx_byte <= '0;
      r_waddr   <= '0;
      r_wdata   <= '0;
      r_we      <= 1'b0;
      r_raddr   <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_is_dump <= w_is_dump_nx;
      r_len     <= w_len_nx;
      r_idx     <= w_idx_nx;
      r_bsel    <= w_bsel_nx;
      r_pack    <= w_pack_nx;
      r_word    <= w_word_nx;
      r_fin     <= w_fin_nx;
      r_tcnt    <= w_tcnt_nx;
      r_wcnt    <= w_wcnt_nx;
      r_trig    <= w_trig_nx;
      r_tx_byte <= w_tx_byte_nx;
      r_waddr   <= w_waddr_nx;
      r_wdata   <= w_wdata_nx;
      r_we      <= w_we_nx;
      r_raddr   <= w_raddr_nx;
      r_busy    <= w_busy_nx;
      r_done    <= w_done_nx;
      r_err     <= w_err_nx;
    end
  end

  assign tx_trigger_out = r_trig;
  assign tx_byte_out    = r_tx_byte;
  assign bram_waddr_out = r_waddr;
  assign bram_wdata_out = r_wdata;
  assign bram_we_out    = r_we;
  assign bram_raddr_out = r_raddr;
  assign busy_out       = r_busy;
  assign done_out       = r_done;
  assign error_out      = r_err;
endmodule

// File: tb/tb_uart_bram_loader.sv
// Self-checking bench for uart_bram_loader: command table plus directed timeout/reset/UART cases.
`timescale 1ns/1ps
module tb_uart_bram_loader;
  localparam int DEPTH = 64;
  localparam int TMO   = 200;
  localparam int AW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          rst_in;
  logic          rx_valid_in;
  logic [7:0]    rx_byte_in;
  logic          tx_busy_in;
  logic          tx_trigger_out;
  logic [7:0]    tx_byte_out;
  logic [AW-1:0] bram_waddr_out;
  logic [31:0]   bram_wdata_out;
  logic          bram_we_out;
  logic [AW-1:0] bram_raddr_out;
  logic [31:0]   bram_rdata_in;
  logic          busy_out;
  logic          done_out;
  logic          error_out;

  uart_bram_loader #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_in(clk), .rst_in(rst_in), .rx_valid_in(rx_valid_in), .rx_byte_in(rx_byte_in),
    .tx_busy_in(tx_busy_in), .tx_trigger_out(tx_trigger_out), .tx_byte_out(tx_byte_out),
    .bram_waddr_out(bram_waddr_out), .bram_wdata_out(bram_wdata_out), .bram_we_out(bram_we_out),
    .bram_raddr_out(bram_raddr_out), .bram_rdata_in(bram_rdata_in), .busy_out(busy_out),
    .done_out(done_out), .error_out(error_out)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Dual-port BRAM with address and output registers (2-cycle read latency)
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] ra_q;
  always @(posedge clk) begin
    if (bram_we_out) mem[bram_waddr_out] <= bram_wdata_out;
    ra_q          <= bram_raddr_out;
    bram_rdata_in <= mem[ra_q];
  end

  logic [56:0] w_outs;
  assign w_outs = {tx_trigger_out, tx_byte_out, bram_waddr_out, bram_wdata_out, bram_we_out,
                   bram_raddr_out, busy_out, done_out, error_out};

  typedef struct { logic [AW-1:0] addr; logic [31:0] data; int unsigned cyc; } wr_t;
  typedef struct { string name; logic [7:0] op; int n; bit err; bit done; } vec_t;

  wr_t         exp_wr[$];
  logic [7:0]  exp_tx[$];
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] pay [DEPTH];
  int          checks = 0, failures = 0;
  int          done_cnt = 0, trig_cnt = 0, tx_hold = 3;
  int unsigned done_cyc = 0, last_we_cyc = 0;
  bit          tx_mute = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Write-port and done monitor
  initial forever begin
    wr_t e;
    @(negedge clk);
    if (bram_we_out) begin
      last_we_cyc = cyc;
      check("wr_expected", exp_wr.size() != 0, 1);
      if (exp_wr.size() != 0) begin
        e = exp_wr.pop_front();
        check("wr_addr", bram_waddr_out, e.addr);
        check("wr_data", bram_wdata_out, e.data);
        check("wr_cycle", cyc, e.cyc);
      end
    end
    if (done_out) begin
      done_cnt++;
      done_cyc = cyc;
      check("done_excl_error", error_out, 0);
    end
  end

  // UART transmitter model: busy for tx_hold cycles after each trigger
  initial begin
    logic [7:0] b, e;
    tx_busy_in = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_trigger_out) begin
        trig_cnt++;
        b = tx_byte_out;
        check("tx_expected", exp_tx.size() != 0, 1);
        if (exp_tx.size() != 0) begin
          e = exp_tx.pop_front();
          check("tx_byte", b, e);
        end
        if (!tx_mute) begin
          tx_busy_in = 1'b1;
          for (int i = 0; i < tx_hold; i++) begin
            @(negedge clk);
            check("trig_during_busy", tx_trigger_out, 0);
            check("tx_byte_stable", tx_byte_out, b);
          end
          tx_busy_in = 1'b0;
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit push, input logic [AW-1:0] a,
                           input logic [31:0] d);
    wr_t e;
    @(negedge clk);
    rx_valid_in = 1'b1;
    rx_byte_in  = b;
    if (push) begin
      e.addr = a; e.data = d; e.cyc = cyc + 1;
      exp_wr.push_back(e);
    end
    @(negedge clk);
    rx_valid_in = 1'b0;
  endtask

  task automatic run_cmd(input string name, input logic [7:0] op, input int n,
                         input bit exp_err, input bit exp_done, input int budget);
    int  d0 = done_cnt;
    int  waited = 0;
    bit  is_ld = (op == 8'h4C);
    bit  is_dp = (op == 8'h44);
    bit  fits  = (n > 0) && (n <= DEPTH);
    logic [15:0] len = 16'(n);
    if (is_dp && fits)
      for (int w = 0; w < n; w++)
        for (int k = 0; k < 4; k++) exp_tx.push_back(ref_mem[w][8*k +: 8]);
    send_byte(op, 1'b0, '0, '0);
    if (is_ld || is_dp) begin
      check({name, "_errclr"}, error_out, 0);
      send_byte(len[7:0], 1'b0, '0, '0);
      send_byte(len[15:8], 1'b0, '0, '0);
    end
    if (is_ld && fits)
      for (int w = 0; w < n; w++) begin
        for (int k = 0; k < 4; k++) send_byte(pay[w][8*k +: 8], k == 3, AW'(w), pay[w]);
        ref_mem[w] = pay[w];
      end
    while (waited < budget && !(!busy_out && (done_cnt != d0 || error_out))) begin
      @(negedge clk);
      waited++;
    end
    check({name, "_completes"}, waited < budget, 1);
    repeat (3) @(negedge clk);
    check({name, "_err"}, error_out, exp_err);
    check({name, "_done"}, done_cnt - d0, exp_done);
    check({name, "_busy"}, busy_out, 0);
    check({name, "_wq"}, exp_wr.size(), 0);
    check({name, "_txq"}, exp_tx.size(), 0);
    if (is_ld && fits) check({name, "_done_lat"}, done_cyc, last_we_cyc + 1);
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  vec_t tbl[11];
  int   t0;

  initial begin
    tbl[0]  = '{"bad_op",      8'h58, 0,      1'b1, 1'b0};
    tbl[1]  = '{"zero_len",    8'h4C, 0,      1'b0, 1'b1};
    tbl[2]  = '{"oversize_ld", 8'h4C, DEPTH+1, 1'b1, 1'b0};
    tbl[3]  = '{"oversize_dp", 8'h44, DEPTH+1, 1'b1, 1'b0};
    tbl[4]  = '{"bad_op_ff",   8'hFF, 0,      1'b1, 1'b0};
    tbl[5]  = '{"dump_zero",   8'h44, 0,      1'b0, 1'b1};
    tbl[6]  = '{"full_load",   8'h4C, DEPTH,  1'b0, 1'b1};
    tbl[7]  = '{"full_dump",   8'h44, DEPTH,  1'b0, 1'b1};
    tbl[8]  = '{"max_len",     8'h4C, 65535,  1'b1, 1'b0};
    tbl[9]  = '{"load3",       8'h4C, 3,      1'b0, 1'b1};
    tbl[10] = '{"dump3",       8'h44, 3,      1'b0, 1'b1};

    rst_in = 1'b1; rx_valid_in = 1'b0; rx_byte_in = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", w_outs, 0);
    rst_in = 1'b0;

    pay[0] = 32'h44332211;
    pay[1] = 32'h88776655;
    run_cmd("rt_load", 8'h4C, 2, 1'b0, 1'b1, 2000);
    check("rt_mem0", ref_mem[0], 32'h44332211);
    run_cmd("rt_dump", 8'h44, 2, 1'b0, 1'b1, 2000);

    for (int i = 0; i < 11; i++) begin
      for (int w = 0; w < DEPTH; w++) pay[w] = $urandom;
      run_cmd(tbl[i].name, tbl[i].op, tbl[i].n, tbl[i].err, tbl[i].done, 5000);
    end

    // Timeout inside a partial word
    send_byte(8'h4C, 1'b0, '0, '0);
    send_byte(8'h01, 1'b0, '0, '0);
    send_byte(8'h00, 1'b0, '0, '0);
    send_byte(8'hAA, 1'b0, '0, '0);
    send_byte(8'hBB, 1'b0, '0, '0);
    repeat (TMO / 2) @(negedge clk);
    check("tmo_mid_err", error_out, 0);
    check("tmo_mid_busy", busy_out, 1);
    repeat (TMO) @(negedge clk);
    check("tmo_err", error_out, 1);
    check("tmo_busy", busy_out, 0);

    // Transmitter that never asserts busy
    tx_mute = 1'b1;
    exp_tx.push_back(ref_mem[0][7:0]);
    send_byte(8'h44, 1'b0, '0, '0);
    send_byte(8'h01, 1'b0, '0, '0);
    send_byte(8'h00, 1'b0, '0, '0);
    for (int i = 0; i < 50 && !error_out; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    check("txhi_err", error_out, 1);
    check("txhi_busy", busy_out, 0);
    check("txhi_txq", exp_tx.size(), 0);
    tx_mute = 1'b0;

    // Asynchronous reset mid-word
    send_byte(8'h4C, 1'b0, '0, '0);
    send_byte(8'h01, 1'b0, '0, '0);
    send_byte(8'h00, 1'b0, '0, '0);
    send_byte(8'h01, 1'b0, '0, '0);
    send_byte(8'h02, 1'b0, '0, '0);
    check("rst_pre_busy", busy_out, 1);
    @(negedge clk);
    #2 rst_in = 1'b1;
    #1 check("rst_async_outs", w_outs, 0);
    @(negedge clk);
    rst_in = 1'b0;
    pay[0] = 32'hCAFEF00D;
    run_cmd("post_rst_load", 8'h4C, 1, 1'b0, 1'b1, 500);
    run_cmd("post_rst_dump", 8'h44, 1, 1'b0, 1'b1, 500);

    // Slow transmitter
    tx_hold = 10000;
    t0 = trig_cnt;
    run_cmd("slow_dump", 8'h44, 1, 1'b0, 1'b1, 60000);
    check("slow_triggers", trig_cnt - t0, 4);
    tx_hold = 3;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
